latch_fifo: RTL and testbench
=============================

// Module: latch_fifo
// PURPOSE
//  Parametrised FIFO whose storage array is built from level-sensitive latches (always_latch),
//  with a clocked controller that generates latch enables and ready/valid handshakes.
//  Successor to the single-latch examples: adds width/depth parameters, a write-enable
//  pipeline that keeps every latch input stable while the latch is open, and flow control.
//  Used as the latch-semantics stress example for the simulator.
// PARAMETERS
//  WIDTH  8  data width in bits (>=1)
//  DEPTH  4  number of latch entries (>=2; need not be a power of two)
// PORTS
//  ck        in   1                      clock; all flops update on posedge
//  rst_n     in   1                      async active-low reset
//  in_valid  in   1                      producer has a word
//  in_ready  out  1                      FIFO can accept a word
//  in_data   in   WIDTH                  write data
//  out_valid out  1                      out_data holds a committed word
//  out_ready in   1                      consumer takes the word
//  out_data  out  WIDTH                  head-of-FIFO data
//  count     out  $clog2(DEPTH+1)        occupied entries, including a pending write
// BEHAVIOUR
//  Reset (rst_n low, takes effect asynchronously):
//   wr_ptr=0, rd_ptr=0, count=0, pend_q=0, wen_q=0, wdata_q=0; in_ready=0, out_valid=0, out_data=0.
//   Latch contents are not reset.
//  Write acceptance at posedge k when in_valid && in_ready:
//   wdata_q<=in_data; wen_q<=onehot(wr_ptr); pend_q<=1; wr_ptr<=wr_ptr+1 (wraps DEPTH-1 -> 0).
//  Storage: entry[i] is transparent only while (wen_q[i] && !ck), i.e. during the low phase of cycle k.
//   It takes its data from wdata_q, never from in_data. The entry closes at posedge k+1.
//   wen_q clears at posedge k+1 unless a new write is accepted at that edge.
//  Commit: pend_q clears at posedge k+1 unless another write is accepted at that edge.
//   The word is readable from cycle k+1 onward (write-to-out_valid latency = 1 cycle after accept).
//  Read at posedge when out_valid && out_ready: rd_ptr<=rd_ptr+1 (wraps).
//  Combinational outputs:
//   out_valid = (count - pend_q) != 0.
//   out_data  = entry[rd_ptr] when out_valid, else 0.
//   in_ready  = rst_n && (count != DEPTH).
//  count update: +1 on write only, -1 on read only, unchanged on both or neither.
//  Boundary rules:
//   - Full: in_ready=0, so in_valid is ignored; there is no write-through even when a read occurs at the same edge.
//   - Empty or only-pending: out_valid=0; there is no bypass from in_data to out_data.
//   - Write slot never equals rd_ptr while that entry is committed. An open latch is therefore never the one being read.
//   - in_data may change at any time after the accept edge without affecting storage.
//   - Reset mid-write: wen_q clears asynchronously and the open latch closes. All words are discarded (count=0).
//     Behaviour after reset release is identical to power-up.
// TESTING
//  1 Reset with WIDTH=8, DEPTH=4 -> count=0, out_valid=0, out_data=0; in_ready=0 while rst_n low, 1 after release.
//  2 Write 0xA5 at edge 1 with out_ready=1 -> out_valid=0 in cycle 1, out_valid=1 with out_data=0xA5
//    in cycle 2; read at edge 3 leaves count=0.
//  3 out_ready=0; write 0x01..0x04 -> in_ready=0 after the 4th accept, count=4; 0x05 is held off.
//    Drain -> 0x01,0x02,0x03,0x04 in order; in_ready=1 after the first read.
//  4 Toggle in_data randomly during the low phase after each accept -> stored values equal the accepted values.
//  5 DEPTH=3: stream 0x10..0x19 with concurrent reads at count=2 -> count stays 2, pointers wrap 2->0,
//    output order 0x10..0x19.
//  6 Drop rst_n mid-low-phase with count=3 and wen_q active -> out_valid=0 and count=0 at once.
//    After release, write 0x3C -> read back 0x3C.

Source files
------------

// File: rtl/latch_fifo.sv
// Ready/valid FIFO whose storage entries are level-sensitive latches.
// Flops hold the write data and a one-hot enable, so a latch input never changes while that latch is open.
module latch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       ck,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pend_q;
  logic [DEPTH-1:0] wen_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] entry [DEPTH];
  logic [CW-1:0]    committed;
  logic             do_write;
  logic             do_read;

  // The word still being latched is counted but not yet readable.
  assign committed = count - CW'(pend_q);
  assign out_valid = (committed != '0);
  assign out_data  = out_valid ? entry[rd_ptr] : '0;
  assign in_ready  = rst_n && (count != FULL_CNT);
  assign do_write  = in_valid && in_ready;
  assign do_read   = out_valid && out_ready;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      pend_q  <= 1'b0;
      wen_q   <= '0;
      wdata_q <= '0;
    end else if (do_write) begin
      wdata_q <= in_data;
      wen_q   <= DEPTH'(1) << wr_ptr;
      pend_q  <= 1'b1;
      wr_ptr  <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
    end else begin
      wen_q   <= '0;
      pend_q  <= 1'b0;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (do_read) begin
      rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({do_write, do_read})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Open only in the low phase after an accept; the rising edge closes it before wdata_q moves.
  always_latch begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wen_q[i] && !ck) entry[i] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_latch_fifo.sv
// Directed bench for latch_fifo: a DEPTH=4 instance driven from a vector table and
// hand sequences, plus a DEPTH=3 instance for the streaming/wrap case.
module tb_latch_fifo;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [2:0] e_cnt;
  } vec_t;

  logic       ck;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;

  logic       s_in_valid;
  logic       s_in_ready;
  logic [7:0] s_in_data;
  logic       s_out_valid;
  logic       s_out_ready;
  logic [7:0] s_out_data;
  logic [1:0] s_count;

  int checks = 0;
  int errors = 0;

  vec_t       vecs [13];
  logic [7:0] t4_vals [3];

  latch_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .ck(ck), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  latch_fifo #(.WIDTH(8), .DEPTH(3)) dut3 (
    .ck(ck), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .count(s_count)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Fields: in_valid, in_data, out_ready | in_ready, out_valid, out_data, count (checked before applying)
    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd1};
    vecs[3]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    vecs[4]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1};
    vecs[5]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01, 3'd2};
    vecs[6]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01, 3'd3};
    vecs[7]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4};
    vecs[8]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 8'h01, 3'd4};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 3'd3};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 3'd2};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 3'd1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    t4_vals[0] = 8'h5A;
    t4_vals[1] = 8'hC3;
    t4_vals[2] = 8'h7E;

    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    s_in_valid  = 1'b0;
    s_in_data   = 8'h00;
    s_out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge ck);
    #1;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'h00);
    checkOutput("rst_in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready_high", 32'(in_ready), 32'd1);
    @(posedge ck);
    #1;

    // Single word latency, then fill to full and drain
    for (int i = 0; i < 13; i++) begin
      checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      checkOutput($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      checkOutput($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
      checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
      applyStimulus(vecs[i].iv, vecs[i].d, vecs[i].ordy);
      @(posedge ck);
      #1;
    end

    // in_data churns after each accept, including during the open low phase
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, t4_vals[i], 1'b0);
      @(posedge ck);
      #1;
      applyStimulus(1'b0, 8'($urandom), 1'b0);
      @(negedge ck);
      #2;
      in_data = 8'($urandom);
    end
    @(posedge ck);
    #1;
    checkOutput("t4_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t4_data%0d", i), 32'(out_data), 32'(t4_vals[i]));
      applyStimulus(1'b0, 8'($urandom), 1'b1);
      @(posedge ck);
      #1;
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t4_empty", 32'(count), 32'd0);

    // DEPTH=3 streaming with simultaneous read and write
    s_out_ready = 1'b1;
    s_in_valid  = 1'b1;
    s_in_data   = 8'h10;
    @(posedge ck);
    #1;
    checkOutput("t5_count1", 32'(s_count), 32'd1);
    checkOutput("t5_pending_invalid", 32'(s_out_valid), 32'd0);
    s_in_data = 8'h11;
    @(posedge ck);
    #1;
    for (int i = 2; i < 10; i++) begin
      checkOutput($sformatf("t5_count_%0d", i), 32'(s_count), 32'd2);
      checkOutput($sformatf("t5_valid_%0d", i), 32'(s_out_valid), 32'd1);
      checkOutput($sformatf("t5_data_%0d", i), 32'(s_out_data), 32'(8'h10 + i - 2));
      s_in_data = 8'(8'h10 + i);
      @(posedge ck);
      #1;
    end
    s_in_valid = 1'b0;
    checkOutput("t5_tail_data18", 32'(s_out_data), 32'h18);
    checkOutput("t5_tail_count2", 32'(s_count), 32'd2);
    @(posedge ck);
    #1;
    checkOutput("t5_tail_data19", 32'(s_out_data), 32'h19);
    checkOutput("t5_tail_count1", 32'(s_count), 32'd1);
    @(posedge ck);
    #1;
    checkOutput("t5_drained_valid", 32'(s_out_valid), 32'd0);
    checkOutput("t5_drained_count", 32'(s_count), 32'd0);
    s_out_ready = 1'b0;

    // Reset in the low phase with the third write's latch open
    applyStimulus(1'b1, 8'h31, 1'b0);
    @(posedge ck);
    #1;
    in_data = 8'h32;
    @(posedge ck);
    #1;
    in_data = 8'h33;
    @(posedge ck);
    #1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t6_pre_count", 32'(count), 32'd3);
    @(negedge ck);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_rst_count", 32'(count), 32'd0);
    checkOutput("t6_rst_data", 32'(out_data), 32'h00);
    checkOutput("t6_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge ck);
    #2;
    rst_n = 1'b1;
    @(posedge ck);
    #1;
    applyStimulus(1'b1, 8'h3C, 1'b0);
    @(posedge ck);
    #1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t6_pending_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_pending_count", 32'(count), 32'd1);
    @(posedge ck);
    #1;
    checkOutput("t6_after_valid", 32'(out_valid), 32'd1);
    checkOutput("t6_after_data", 32'(out_data), 32'h3C);
    out_ready = 1'b1;
    @(posedge ck);
    #1;
    out_ready = 1'b0;
    checkOutput("t6_final_count", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
